// File: rtl/invsqrt_arbiter.sv
// rtl/invsqrt_arbiter.sv - round-robin arbiter sharing one inverse-sqrt pipe across NUM_REQ lanes.
// Optional tag_err checker output is built when INVSQRT_ARB_TAG_CHECK_EN is defined.
module invsqrt_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int PIPE_LAT = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_vld,
  input  logic [16*NUM_REQ-1:0]  req_x,
  output logic [NUM_REQ-1:0]     req_rdy,
  input  logic                   hold,
  output logic [15:0]            pipe_x,
  output logic                   pipe_x_vld,
  input  logic [15:0]            pipe_y,
  input  logic                   pipe_y_vld,
  output logic [NUM_REQ-1:0]     rsp_vld,
  output logic [15:0]            rsp_y,
  output logic                   busy,
`ifdef INVSQRT_ARB_TAG_CHECK_EN
  output logic                   drained,
  output logic                   tag_err
`else
  output logic                   drained
`endif
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(PIPE_LAT + 2);

  logic [IDW-1:0]                rr_ptr_q, rr_ptr_d;
  logic [15:0]                   pipe_x_q;
  logic                          pipe_x_vld_q;
  logic [IDW-1:0]                pipe_id_q;
  logic [PIPE_LAT-1:0]           tag_vld_q;
  logic [PIPE_LAT-1:0][IDW-1:0]  tag_id_q;
  logic [CW-1:0]                 cnt_q, cnt_d;

  logic                          found;
  logic [IDW-1:0]                gnt_id;
  logic [15:0]                   gnt_x;
  int                            idx;
  logic                          tag_out_vld;
  logic [IDW-1:0]                tag_out_id;

  // Search starts at rr_ptr and wraps; first valid lane wins unless hold blocks all grants.
  always_comb begin
    req_rdy = '0;
    gnt_id  = '0;
    gnt_x   = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && !hold && req_vld[idx]) begin
        found        = 1'b1;
        req_rdy[idx] = 1'b1;
        gnt_id       = IDW'(idx);
        gnt_x        = req_x[16*idx +: 16];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (found) begin
      if (gnt_id == IDW'(NUM_REQ - 1)) rr_ptr_d = '0;
      else                             rr_ptr_d = gnt_id + 1'b1;
    end
  end

  // Spurious results at zero count saturate rather than wrap the counter.
  always_comb begin
    cnt_d = cnt_q;
    if (pipe_x_vld_q && !pipe_y_vld)                     cnt_d = cnt_q + 1'b1;
    else if (!pipe_x_vld_q && pipe_y_vld && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      pipe_x_q     <= '0;
      pipe_x_vld_q <= 1'b0;
      pipe_id_q    <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      cnt_q        <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      pipe_x_vld_q <= found;
      if (found) begin
        pipe_x_q  <= gnt_x;
        pipe_id_q <= gnt_id;
      end
      tag_vld_q[0] <= pipe_x_vld_q;
      tag_id_q[0]  <= pipe_id_q;
      for (int s = 1; s < PIPE_LAT; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
      cnt_q <= cnt_d;
    end
  end

  assign tag_out_vld = tag_vld_q[PIPE_LAT-1];
  assign tag_out_id  = tag_id_q[PIPE_LAT-1];

  // Results route straight from the pipe; a result with no valid tag is dropped.
  always_comb begin
    rsp_vld = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_vld[i] = pipe_y_vld && tag_out_vld && (tag_out_id == IDW'(i));
    end
  end

  assign rsp_y      = pipe_y;
  assign pipe_x     = pipe_x_q;
  assign pipe_x_vld = pipe_x_vld_q;
  assign busy       = (cnt_q != '0);
  assign drained    = hold && (cnt_q == '0) && !pipe_x_vld_q;

`ifdef INVSQRT_ARB_TAG_CHECK_EN
  logic tag_err_q;
  logic underflow;

  assign underflow = !pipe_x_vld_q && pipe_y_vld && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst)                                           tag_err_q <= 1'b0;
    else if ((pipe_y_vld != tag_out_vld) || underflow) tag_err_q <= 1'b1;
  end

  assign tag_err = tag_err_q;
`endif

endmodule

// File: tb/tb_invsqrt_arbiter.sv
// tb/tb_invsqrt_arbiter.sv - self-checking bench for invsqrt_arbiter with a fixed-latency pipe stub.
module tb_invsqrt_arbiter;
  localparam int N   = 4;
  localparam int L   = 17;
  localparam int LAT = L + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_vld;
  logic [16*N-1:0] req_x;
  logic [N-1:0]   req_rdy;
  logic           hold;
  logic [15:0]    pipe_x;
  logic           pipe_x_vld;
  logic [15:0]    pipe_y;
  logic           pipe_y_vld;
  logic [N-1:0]   rsp_vld;
  logic [15:0]    rsp_y;
  logic           busy;
  logic           drained;
`ifdef INVSQRT_ARB_TAG_CHECK_EN
  logic           tag_err;
`endif

  always #5 clk = ~clk;

  invsqrt_arbiter #(.NUM_REQ(N), .PIPE_LAT(L)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
    .hold(hold), .pipe_x(pipe_x), .pipe_x_vld(pipe_x_vld), .pipe_y(pipe_y),
    .pipe_y_vld(pipe_y_vld), .rsp_vld(rsp_vld), .rsp_y(rsp_y), .busy(busy),
`ifdef INVSQRT_ARB_TAG_CHECK_EN
    .drained(drained), .tag_err(tag_err)
`else
    .drained(drained)
`endif
  );

  typedef struct {
    int          lane;
    logic [15:0] y;
    int          due;
  } exp_t;

  typedef struct {
    logic [N-1:0] vld;
    logic         hold;
    logic [N-1:0] rdy;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  exp_t        sbq[$];
  vec_t        tv[12];
  logic        pm_vld[0:L];
  logic [15:0] pm_x[0:L];
  logic        spur = 1'b0;

  function automatic logic [15:0] fmodel(input logic [15:0] x);
    return (x == 16'h4080) ? 16'h3F00 : (x ^ 16'hA5A5);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic rand_x();
    for (int i = 0; i < N; i++) req_x[16*i +: 16] = 16'($urandom);
  endtask

  // One clock: log handshakes, advance the pipe stub, then score any response.
  task automatic tick();
    exp_t        e;
    logic [N-1:0] oh;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (req_vld[i] && req_rdy[i]) sbq.push_back('{i, fmodel(req_x[16*i +: 16]), cyc + LAT});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      for (int s = 0; s <= L; s++) begin pm_vld[s] = 1'b0; pm_x[s] = 16'h0; end
      pipe_y_vld = 1'b0;
      pipe_y     = 16'h0;
      sbq.delete();
    end else begin
      for (int s = L; s > 0; s--) begin pm_vld[s] = pm_vld[s-1]; pm_x[s] = pm_x[s-1]; end
      pm_vld[0]  = pipe_x_vld;
      pm_x[0]    = pipe_x;
      pipe_y_vld = pm_vld[L] | spur;
      pipe_y     = fmodel(pm_x[L]);
    end
    #1;
    if (rsp_vld != '0) begin
      if (sbq.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_vld), 64'(0));
      end else begin
        e  = sbq.pop_front();
        oh = N'(1 << e.lane);
        check("rsp", {cyc, 12'h0, rsp_vld, rsp_y}, {e.due, 12'h0, oh, e.y});
      end
    end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
      e  = sbq.pop_front();
      oh = N'(1 << e.lane);
      check("rsp_missing", {cyc, 12'h0, rsp_vld, rsp_y}, {e.due, 12'h0, oh, e.y});
    end
  endtask

  task automatic do_reset();
    req_vld = '0;
    hold    = 1'b0;
    rst     = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    req_vld = '0;
    for (int k = 0; k < budget && sbq.size() != 0; k++) tick();
    if (sbq.size() != 0) begin
      check("drain_timeout", 64'(sbq.size()), 64'(0));
      sbq.delete();
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_vld    = '0;
    req_x      = '0;
    hold       = 1'b0;
    pipe_y     = 16'h0;
    pipe_y_vld = 1'b0;
    for (int s = 0; s <= L; s++) begin pm_vld[s] = 1'b0; pm_x[s] = 16'h0; end

    tv[0]  = '{4'b0000, 1'b0, 4'b0000};
    tv[1]  = '{4'b1111, 1'b0, 4'b0001};
    tv[2]  = '{4'b1111, 1'b1, 4'b0000};
    tv[3]  = '{4'b0001, 1'b0, 4'b0001};
    tv[4]  = '{4'b1100, 1'b0, 4'b0100};
    tv[5]  = '{4'b0110, 1'b0, 4'b0010};
    tv[6]  = '{4'b1010, 1'b0, 4'b1000};
    tv[7]  = '{4'b1010, 1'b0, 4'b0010};
    tv[8]  = '{4'b0000, 1'b0, 4'b0000};
    tv[9]  = '{4'b1111, 1'b0, 4'b0100};
    tv[10] = '{4'b1001, 1'b0, 4'b1000};
    tv[11] = '{4'b1000, 1'b1, 4'b0000};

    do_reset();
    #1;
    check("reset_rdy", 64'(req_rdy), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_rsp", 64'(rsp_vld), 64'(0));
    check("reset_pxv", 64'(pipe_x_vld), 64'(0));
    check("reset_drained_h0", 64'(drained), 64'(0));
    hold = 1'b1;
    #1;
    check("reset_drained_h1", 64'(drained), 64'(1));
    hold = 1'b0;

    for (int i = 0; i < 12; i++) begin
      req_vld = tv[i].vld;
      hold    = tv[i].hold;
      rand_x();
      #1;
      check($sformatf("arb_vec%0d", i), 64'(req_rdy), 64'(tv[i].rdy));
      tick();
    end
    hold = 1'b0;
    wait_drain(60);

    // Single lane 2 operand with known result.
    do_reset();
    rand_x();
    req_x[47:32] = 16'h4080;
    req_vld      = 4'b0100;
    #1;
    check("single_rdy", 64'(req_rdy), 64'(4'b0100));
    tick();
    req_vld = '0;
    check("single_pipe_x", {47'h0, pipe_x_vld, pipe_x}, {47'h0, 1'b1, 16'h4080});
    wait_drain(60);

    // All lanes saturated for 8 cycles.
    do_reset();
    req_vld = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      rand_x();
      #1;
      check($sformatf("rr_seq%0d", i), 64'(req_rdy), 64'(1 << (i % 4)));
      tick();
    end
    wait_drain(60);

    // Hold with five operations in flight.
    do_reset();
    req_vld = 4'b0001;
    for (int i = 0; i < 5; i++) begin rand_x(); #1; tick(); end
    hold = 1'b1;
    #1;
    check("hold_rdy", 64'(req_rdy), 64'(0));
    for (int k = 0; k < 60 && sbq.size() != 0; k++) begin
      check("hold_busy", 64'(busy), 64'(1));
      tick();
    end
    check("hold_all_done", 64'(sbq.size()), 64'(0));
    check("hold_last_rsp", {62'h0, busy, drained}, {62'h0, 1'b1, 1'b0});
    tick();
    check("hold_drained", {62'h0, busy, drained}, {62'h0, 1'b0, 1'b1});
    hold    = 1'b0;
    req_vld = '0;

    // Reset with ten operations in flight.
    do_reset();
    req_vld = 4'b1111;
    for (int i = 0; i < 10; i++) begin rand_x(); #1; tick(); end
    req_vld = '0;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_pxv", 64'(pipe_x_vld), 64'(0));
    for (int k = 0; k < 30; k++) tick();
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_sb", 64'(sbq.size()), 64'(0));

`ifdef INVSQRT_ARB_TAG_CHECK_EN
    do_reset();
    check("tag_err_reset", 64'(tag_err), 64'(0));
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    check("tag_err_set", 64'(tag_err), 64'(1));
    for (int k = 0; k < 5; k++) tick();
    check("tag_err_sticky", 64'(tag_err), 64'(1));
    do_reset();
    check("tag_err_cleared", 64'(tag_err), 64'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
